// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//   Round-robin arbiter and sequencer for a 2:1 mux datapath. Two valid/ready
//   requesters (a, b) share one mux. The block owns the mux select, grants one
//   requester at a time with a bounded burst length, and registers the muxed
//   beat into a one-entry output stage feeding a valid/ready consumer.
//
// Parameters
//   WIDTH     data width of a_data, b_data, out_data
//   MAX_HOLD  max beats per grant while the other side is waiting (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active low
//   a_valid    in   requester a has a beat
//   a_data     in   requester a beat
//   a_ready    out  a beat accepted when a_valid & a_ready
//   b_valid    in   requester b has a beat
//   b_data     in   requester b beat
//   b_ready    out  b beat accepted when b_valid & b_ready
//   out_valid  out  output stage holds a beat
//   out_data   out  registered muxed beat
//   out_ready  in   consumer accepts when out_valid & out_ready
//   sel        out  mux select, 0 = a, 1 = b (registered)
//   busy       out  1 while a grant is held
//   a_lock     in   (MUX_ARB_LOCK_EN only) a keeps its grant past MAX_HOLD
//   b_lock     in   (MUX_ARB_LOCK_EN only) b keeps its grant past MAX_HOLD
//
// Configuration
//   MUX_ARB_LOCK_EN  when defined, adds a_lock/b_lock. While the granted side
//                    holds its lock the burst-length release is suppressed and
//                    the beat count saturates at MAX_HOLD; the grant is still
//                    released as soon as the granted side drops valid.
// -----------------------------------------------------------------------------
module mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
`ifdef MUX_ARB_LOCK_EN
    input  logic             a_lock,
    input  logic             b_lock,
`endif
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    localparam int            CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    // Registered state and outputs
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rr_b_q, rr_b_d;      // 1: b held the last grant, a wins a tie
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    // Combinational helpers
    logic             a_lock_s, b_lock_s;
    logic             granted_s;
    logic             own_valid_s, oth_valid_s, own_lock_s;
    logic [WIDTH-1:0] own_data_s;
    state_t           other_s;
    logic             hold_full_s;
    logic             own_ready_s;
    logic             xfer_s;
    logic             release_s;
    logic [CW-1:0]    cnt_inc_s;

`ifdef MUX_ARB_LOCK_EN
    assign a_lock_s = a_lock;
    assign b_lock_s = b_lock;
`else
    assign a_lock_s = 1'b0;
    assign b_lock_s = 1'b0;
`endif

    // Fold the two grant states onto an "own side" / "other side" view.
    always_comb begin
        granted_s   = 1'b0;
        own_valid_s = 1'b0;
        oth_valid_s = 1'b0;
        own_lock_s  = 1'b0;
        own_data_s  = {WIDTH{1'b0}};
        other_s     = IDLE;
        case (state_q)
            GNT_A: begin
                granted_s   = 1'b1;
                own_valid_s = a_valid;
                oth_valid_s = b_valid;
                own_lock_s  = a_lock_s;
                own_data_s  = a_data;
                other_s     = GNT_B;
            end
            GNT_B: begin
                granted_s   = 1'b1;
                own_valid_s = b_valid;
                oth_valid_s = a_valid;
                own_lock_s  = b_lock_s;
                own_data_s  = b_data;
                other_s     = GNT_A;
            end
            default: begin
                granted_s   = 1'b0;
                own_valid_s = 1'b0;
                oth_valid_s = 1'b0;
                own_lock_s  = 1'b0;
                own_data_s  = {WIDTH{1'b0}};
                other_s     = IDLE;
            end
        endcase
    end

    // A full burst with the other side waiting spends one cycle handing over:
    // ready is withheld so the granted side cannot push a beat past MAX_HOLD.
    assign hold_full_s = (cnt_q == CNT_MAX) & oth_valid_s & ~own_lock_s;
    assign own_ready_s = granted_s & (~out_valid_q | out_ready) & ~hold_full_s;
    assign xfer_s      = own_valid_s & own_ready_s;
    assign release_s   = granted_s & (~own_valid_s | hold_full_s);

    assign a_ready   = own_ready_s & (state_q == GNT_A);
    assign b_ready   = own_ready_s & (state_q == GNT_B);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign busy      = busy_q;

    // Grant sequencing: next state, round-robin pointer and burst counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_b_d    = rr_b_q;
        cnt_inc_s = cnt_q;
        case (state_q)
            IDLE: begin
                if (a_valid & b_valid) begin
                    state_d = rr_b_q ? GNT_A : GNT_B;
                end else if (a_valid) begin
                    state_d = GNT_A;
                end else if (b_valid) begin
                    state_d = GNT_B;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_A, GNT_B: begin
                if (release_s) begin
                    rr_b_d = (state_q == GNT_B);
                    cnt_d  = CNT_ZERO;
                    if (oth_valid_s) begin
                        state_d = other_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    // Count saturates at MAX_HOLD (only reachable while locked
                    // or while the other side is momentarily idle).
                    if (xfer_s && (cnt_q != CNT_MAX)) begin
                        cnt_inc_s = cnt_q + CNT_ONE;
                    end else begin
                        cnt_inc_s = cnt_q;
                    end
                    // Nobody waiting: start a fresh burst window.
                    if ((cnt_inc_s == CNT_MAX) && !oth_valid_s && !own_lock_s) begin
                        cnt_d = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // One-entry output stage and registered select/busy.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = own_data_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end
        sel_d  = (state_d == GNT_B);
        busy_d = (state_d != IDLE);
    end

    // State register; asynchronous reset drops any beat held in the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            rr_b_q      <= 1'b1;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_b_q      <= rr_b_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_arbiter
//   Directed bench for mux_arbiter. A cycle-level behavioural model (owner,
//   beats-in-grant, last owner, one-slot output buffer) predicts every output
//   each cycle; hand-computed beat streams and literal checks pin the model.
//   Inputs change 1 time unit after the rising edge; outputs are compared on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_mux_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data  = 8'h00;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data  = 8'h00;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b1;
    logic             sel;
    logic             busy;
    logic [1:0]       lk;
`ifdef MUX_ARB_LOCK_EN
    logic             a_lock = 1'b0;
    logic             b_lock = 1'b0;
    assign lk = {b_lock, a_lock};
`else
    assign lk = 2'b00;
`endif

    always #5 clk = ~clk;

    mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
`ifdef MUX_ARB_LOCK_EN
        .a_lock   (a_lock),
        .b_lock   (b_lock),
`endif
        .clk      (clk),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .sel      (sel),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus sources ----------------
    int a_acc = 0, b_acc = 0;          // accepted beats (written by monitor only)
    int a_start = 0, b_start = 0;
    int a_goal = 0, b_goal = 0;
    logic [7:0] a_base = 8'h00, b_base = 8'h00;
    logic [7:0] got[$];

    task automatic drive();
        a_valid = ((a_acc - a_start) < a_goal);
        a_data  = a_base + 8'(a_acc - a_start);
        b_valid = ((b_acc - b_start) < b_goal);
        b_data  = b_base + 8'(b_acc - b_start);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 nobody, 0 = a, 1 = b
    int         m_owner = -1;
    int         m_beats = 0;
    int         m_last  = 1;
    logic       m_ov    = 1'b0;
    logic [7:0] m_od    = 8'h00;

    function automatic logic vld(input int s);
        return (s == 0) ? a_valid : b_valid;
    endfunction

    function automatic logic [7:0] dat(input int s);
        return (s == 0) ? a_data : b_data;
    endfunction

    function automatic logic lck(input int s);
        return lk[s];
    endfunction

    // The owner hands over after MAX_HOLD beats if the other side waits.
    function automatic logic m_handover();
        if (m_owner < 0) return 1'b0;
        return (m_beats >= MAX_HOLD) && vld(1 - m_owner) && !lck(m_owner);
    endfunction

    function automatic logic m_ready(input int s);
        if (m_owner != s) return 1'b0;
        if (m_ov && !out_ready) return 1'b0;
        if (m_handover()) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_beats = 0; m_last = 1; m_ov = 1'b0; m_od = 8'h00;
            end else begin
                int acc;
                int o;
                acc = -1;
                if (m_owner >= 0) begin
                    o = m_owner;
                    if (!vld(o) || m_handover()) begin
                        m_last  = o;
                        m_beats = 0;
                        m_owner = vld(1 - o) ? 1 - o : -1;
                    end else begin
                        if (m_ready(o)) begin
                            acc = o;
                            m_beats = (m_beats + 1 > MAX_HOLD) ? MAX_HOLD : m_beats + 1;
                        end
                        if (m_beats == MAX_HOLD && !vld(1 - o) && !lck(o)) m_beats = 0;
                    end
                end else begin
                    if (a_valid && b_valid) m_owner = 1 - m_last;
                    else if (a_valid)       m_owner = 0;
                    else if (b_valid)       m_owner = 1;
                end
                if (acc >= 0) begin
                    m_ov = 1'b1;
                    m_od = dat(acc);
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    // ---------------- compare + monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("a_ready",   a_ready,   m_ready(0));
                check("b_ready",   b_ready,   m_ready(1));
                check("sel",       sel,       m_owner == 1);
                check("busy",      busy,      m_owner >= 0);
                check("out_valid", out_valid, m_ov);
                check("out_data",  out_data,  m_od);
            end
            if (a_valid && a_ready) a_acc++;
            if (b_valid && b_ready) b_acc++;
            if (out_valid && out_ready) got.push_back(out_data);
        end
    end

    task automatic do_reset();
        a_goal = 0; b_goal = 0;
        drive();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_beats(input int n, input int limit);
        for (int i = 0; i < limit && got.size() < n; i++) tick();
    endtask

    task automatic start_src(input logic [7:0] ab, input int ag, input logic [7:0] bb, input int bg);
        a_start = a_acc; b_start = b_acc;
        a_base = ab; a_goal = ag;
        b_base = bb; b_goal = bg;
        got.delete();
        drive();
    endtask

    initial begin
        automatic logic [7:0] exp3[12] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1,
                                          8'hB2, 8'hB3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        automatic logic [7:0] exp6[9]  = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65,
                                          8'h70, 8'h71, 8'h72};
        int first_k;
        int run;

        // 1: reset values, then idle with no requests
        #1 rst_n = 1'b0;
        #1;
        check("t1_rst_out_valid", out_valid, 1'b0);
        check("t1_rst_out_data",  out_data,  8'h00);
        check("t1_rst_sel",       sel,       1'b0);
        check("t1_rst_busy",      busy,      1'b0);
        check("t1_rst_a_ready",   a_ready,   1'b0);
        check("t1_rst_b_ready",   b_ready,   1'b0);
        chk_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t1_idle_busy", busy, 1'b0);

        // 2: a only, six beats, latency 2, no gaps
        start_src(8'h11, 6, 8'h00, 0);
        first_k = 0;
        run = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (out_valid && first_k == 0) first_k = k;
            if (out_valid) run++;
        end
        check("t2_latency", first_k, 2);
        check("t2_valid_cycles", run, 6);
        check("t2_count", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++)
            check($sformatf("t2_beat%0d", i), got[i], 8'h11 + 8'(i));

        // 3: a and b both continuous; bursts of MAX_HOLD alternate
        do_reset();
        start_src(8'hA0, 8, 8'hB0, 100);
        wait_beats(12, 60);
        check("t3_count", got.size() >= 12, 1'b1);
        for (int i = 0; i < got.size() && i < 12; i++)
            check($sformatf("t3_beat%0d", i), got[i], exp3[i]);
        b_goal = 0;
        drive();
        repeat (3) tick();

        // 4: consumer stalls for three cycles mid-burst
        do_reset();
        start_src(8'h40, 8, 8'h00, 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3) out_ready = 1'b0;
            if (k == 6) out_ready = 1'b1;
            if (k >= 3 && k <= 5) begin
                #1;
                check($sformatf("t4_stall_a_ready%0d", k), a_ready, 1'b0);
                check($sformatf("t4_stall_data%0d", k), out_data, 8'h41);
            end
        end
        check("t4_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++)
            check($sformatf("t4_beat%0d", i), got[i], 8'h40 + 8'(i));

        // 5: asynchronous reset while b is granted with a beat held
        do_reset();
        start_src(8'h00, 0, 8'hC0, 10);
        repeat (3) tick();
        check("t5_pre_sel", sel, 1'b1);
        check("t5_pre_out_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", out_valid, 1'b0);
        check("t5_rst_sel", sel, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_b_ready", b_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        a_start = a_acc; a_base = 8'hD0; a_goal = 2;
        drive();
        tick();
        check("t5_tie_sel", sel, 1'b0);
        check("t5_tie_a_ready", a_ready, 1'b1);
        check("t5_tie_b_ready", b_ready, 1'b0);
        repeat (6) tick();
        b_goal = 0;
        drive();
        repeat (3) tick();

`ifdef MUX_ARB_LOCK_EN
        // 6: a locked keeps the grant past MAX_HOLD until it drops valid
        do_reset();
        a_lock = 1'b1;
        start_src(8'h60, 6, 8'h70, 3);
        wait_beats(9, 60);
        check("t6_count", got.size(), 9);
        for (int i = 0; i < got.size() && i < 9; i++)
            check($sformatf("t6_beat%0d", i), got[i], exp6[i]);
        a_lock = 1'b0;
        repeat (3) tick();
`else
        check("t6_exp_len", $size(exp6), 9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
